// File: rtl/ifetch_bus_arbiter_if.sv
// ifetch_bus_arbiter_if: fetch, secondary and memory bus signals
// slave = arbiter view, master = requester/memory view
interface ifetch_bus_arbiter_if;
  logic        f_en;
  logic [31:0] f_address;
  logic        f_squashn;
  logic        f_wait;
  logic [31:0] f_readdata;
  logic [31:0] f_ecause;
  logic        d_req;
  logic [31:0] d_address;
  logic        d_valid;
  logic [31:0] d_readdata;
  logic        mem_req;
  logic [31:0] mem_address;
  logic        mem_ack;
  logic [31:0] mem_readdata;
  logic        mem_abort;

  modport slave (
    input  f_en, f_address, f_squashn,
    input  d_req, d_address,
    input  mem_ack, mem_readdata,
    output f_wait, f_readdata, f_ecause,
    output d_valid, d_readdata,
    output mem_req, mem_address, mem_abort
  );

  modport master (
    output f_en, f_address, f_squashn,
    output d_req, d_address,
    output mem_ack, mem_readdata,
    input  f_wait, f_readdata, f_ecause,
    input  d_valid, d_readdata,
    input  mem_req, mem_address, mem_abort
  );
endinterface

// File: rtl/ifetch_bus_arbiter.sv
// ifetch_bus_arbiter: one-outstanding-read arbiter, fetch vs secondary
// optional hung-read abort enabled by IBUS_TIMEOUT_EN
module ifetch_bus_arbiter #(
  parameter int STARVE_LIMIT   = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic resetn,
  ifetch_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, F_BUSY, D_BUSY, F_DROP
  } state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e      state_q;
  logic [3:0]  starve_q, starve_d;
  logic        mem_req_q;
  logic [31:0] mem_address_q;
  logic        f_wait_q;
  logic [31:0] f_readdata_q;
  logic        d_valid_q;
  logic [31:0] d_readdata_q;
  logic        d_win, grant_d, grant_f;
  logic        tmo_hit;

  // grant decode and saturating starvation count
  always_comb begin
    d_win   = bus.d_req && (starve_q >= STARVE_MAX);
    grant_d = (state_q == IDLE) && bus.d_req &&
              (d_win || !bus.f_en);
    grant_f = (state_q == IDLE) && bus.f_en && !d_win;
    if (!bus.d_req || grant_d)
      starve_d = '0;
    else if (starve_q != 4'hF)
      starve_d = starve_q + 4'd1;
    else
      starve_d = starve_q;
  end

  // main sequencer with registered bus outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      mem_req_q     <= 1'b0;
      mem_address_q <= '0;
      f_wait_q      <= 1'b1;
      f_readdata_q  <= '0;
      d_valid_q     <= 1'b0;
      d_readdata_q  <= '0;
    end else begin
      starve_q  <= starve_d;
      f_wait_q  <= 1'b1;
      d_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            mem_address_q <= bus.d_address;
            mem_req_q     <= 1'b1;
            state_q       <= D_BUSY;
          end else if (grant_f) begin
            mem_address_q <= bus.f_address;
            mem_req_q     <= 1'b1;
            state_q       <= bus.f_squashn ? F_BUSY : F_DROP;
          end
        end
        F_BUSY: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
            if (bus.f_squashn) begin
              f_readdata_q <= bus.mem_readdata;
              f_wait_q     <= 1'b0;
            end
          end else if (!bus.f_squashn) begin
            if (tmo_hit) begin
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              state_q <= F_DROP;
            end
          end else if (tmo_hit) begin
            mem_req_q    <= 1'b0;
            state_q      <= IDLE;
            f_readdata_q <= '0;
            f_wait_q     <= 1'b0;
          end
        end
        D_BUSY: begin
          if (bus.mem_ack || tmo_hit) begin
            mem_req_q    <= 1'b0;
            state_q      <= IDLE;
            d_valid_q    <= 1'b1;
            d_readdata_q <= bus.mem_ack ? bus.mem_readdata : '0;
          end
        end
        F_DROP: begin
          if (bus.mem_ack || tmo_hit) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IBUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0]  tmo_q;
  logic        mem_abort_q;
  logic [31:0] f_ecause_q;
  logic        fetch_err;

  assign tmo_hit = (state_q != IDLE) && !bus.mem_ack &&
                   (tmo_q == TMO_LAST);
  assign fetch_err = (state_q == F_BUSY) && bus.f_squashn &&
                     tmo_hit;

  // busy-cycle counter, abort pulse and fetch error cause
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_q       <= '0;
      mem_abort_q <= 1'b0;
      f_ecause_q  <= '0;
    end else begin
      tmo_q       <= (state_q == IDLE) ? '0 : tmo_q + 8'd1;
      mem_abort_q <= tmo_hit;
      if (grant_f)
        f_ecause_q <= '0;
      else if (fetch_err)
        f_ecause_q <= 32'h1;
    end
  end

  assign bus.mem_abort = mem_abort_q;
  assign bus.f_ecause  = f_ecause_q;
`else
  logic unused_tmo;
  assign unused_tmo    = ^TIMEOUT_CYCLES;
  assign tmo_hit       = 1'b0;
  assign bus.mem_abort = 1'b0;
  assign bus.f_ecause  = '0;
`endif

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_address = mem_address_q;
  assign bus.f_wait      = f_wait_q;
  assign bus.f_readdata  = f_readdata_q;
  assign bus.d_valid     = d_valid_q;
  assign bus.d_readdata  = d_readdata_q;
endmodule
